// File: rtl/tb_axi_rsp_delay.sv
// Simulation-only AXI4 response-latency injector: delays every R beat and B response by a
//   fixed number of cycles (Latency); AW/W/AR and their readies pass straight through.
// Backpressure: cluster stalls are absorbed by the R/B buffers, and memory is stalled via r_ready/b_ready when full.
// Ports (top): clk_i, rst_ni (async, active low), slv_req_i/slv_rsp_o (cluster side),
//   mst_req_o/mst_rsp_i (memory side). Sub-module tb_axi_rsp_delay_fifo is one timestamped buffer.

package tb_axi_rsp_delay_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } narrow_out_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } narrow_out_resp_t;
endpackage

// Timestamped in-order buffer: an entry pushed at cycle t is offered at t+Latency at the earliest.
// Latency: Latency cycles from push to first out_vld (never fall-through).
// Backpressure: in_rdy = !full from registered occupancy only; out_rdy low holds the head stable.
// Ports: cycle_i (free-running stamp source), in_vld/in_rdy/in_dat, out_vld/out_rdy/out_dat.
module tb_axi_rsp_delay_fifo #(
  parameter type dat_t    = logic,
  parameter int  Depth    = 4,
  parameter int  Latency  = 8,
  parameter int  CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CntWidth-1:0] cycle_i,
  input  logic                in_vld,
  output logic                in_rdy,
  input  dat_t                in_dat,
  output logic                out_vld,
  input  logic                out_rdy,
  output dat_t                out_dat
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OccW = $clog2(Depth + 1);
  localparam logic [OccW-1:0]     DepthOcc = OccW'(Depth);
  localparam logic [PtrW-1:0]     LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntWidth-1:0] LatCnt   = CntWidth'(Latency);

  dat_t                dat_q   [Depth];
  logic [CntWidth-1:0] stamp_q [Depth];
  // Sticky "old enough" flag per slot: once an entry has aged to Latency it stays eligible,
  // so a long stall cannot let the modular age wrap back below Latency.
  logic [Depth-1:0]    ripe_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]     occ_q;
  logic                full, empty, push, pop;
  logic [CntWidth-1:0] head_age;

  assign full     = (occ_q == DepthOcc);
  assign empty    = (occ_q == '0);
  assign in_rdy   = ~full;
  assign push     = in_vld & ~full;
  assign head_age = cycle_i - stamp_q[rd_ptr_q];
  // Only the head is gated, so later eligible entries wait and order is preserved.
  assign out_vld  = ~empty & (ripe_q[rd_ptr_q] | (head_age >= LatCnt));
  assign out_dat  = dat_q[rd_ptr_q];
  assign pop      = out_vld & out_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      occ_q <= occ_q + 1'b1;
      else if (pop && !push) occ_q <= occ_q - 1'b1;
    end
  end

  // Payload storage needs no reset: empty slots are never presented and ripe is cleared on push.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (push && (wr_ptr_q == PtrW'(i))) begin
        dat_q[i]   <= in_dat;
        stamp_q[i] <= cycle_i;
        ripe_q[i]  <= 1'b0;
      end else if ((cycle_i - stamp_q[i]) == LatCnt) begin
        ripe_q[i]  <= 1'b1;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
  a_head_stable:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   (out_vld && !out_rdy) |=> (out_vld && $stable(out_dat)));
endmodule

// AXI response-latency injector top: R and B each go through a timestamped buffer.
// Latency: AW/W/AR and their readies combinational; R/B delayed by exactly Latency cycles when unstalled.
// Backpressure: cluster r_ready/b_ready stall the buffers; memory sees r_ready/b_ready = buffer not full.
module tb_axi_rsp_delay #(
  parameter type req_t    = tb_axi_rsp_delay_pkg::narrow_out_req_t,
  parameter type rsp_t    = tb_axi_rsp_delay_pkg::narrow_out_resp_t,
  parameter type r_chan_t = tb_axi_rsp_delay_pkg::r_chan_t,
  parameter type b_chan_t = tb_axi_rsp_delay_pkg::b_chan_t,
  parameter int  Latency  = 8,
  parameter int  RDepth   = 16,
  parameter int  BDepth   = 8,
  parameter int  CntWidth = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t slv_req_i,
  output rsp_t slv_rsp_o,
  output req_t mst_req_o,
  input  rsp_t mst_rsp_i
);
  if (Latency < 1) begin : g_bad_latency
    $error("Latency must be at least 1");
  end
  if (RDepth < 1 || BDepth < 1) begin : g_bad_depth
    $error("RDepth and BDepth must be at least 1");
  end
  if (CntWidth < 31 && Latency >= (2 ** CntWidth)) begin : g_bad_cnt
    $error("Latency must be below 2**CntWidth");
  end

  logic [CntWidth-1:0] cycle_q;
  logic                r_in_rdy, r_out_vld, b_in_rdy, b_out_vld;
  r_chan_t             r_out_dat;
  b_chan_t             b_out_dat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_q <= '0;
    else         cycle_q <= cycle_q + 1'b1;
  end

  tb_axi_rsp_delay_fifo #(
    .dat_t(r_chan_t), .Depth(RDepth), .Latency(Latency), .CntWidth(CntWidth)
  ) i_r_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cycle_i (cycle_q),
    .in_vld  (mst_rsp_i.r_valid),
    .in_rdy  (r_in_rdy),
    .in_dat  (mst_rsp_i.r),
    .out_vld (r_out_vld),
    .out_rdy (slv_req_i.r_ready),
    .out_dat (r_out_dat)
  );

  tb_axi_rsp_delay_fifo #(
    .dat_t(b_chan_t), .Depth(BDepth), .Latency(Latency), .CntWidth(CntWidth)
  ) i_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cycle_i (cycle_q),
    .in_vld  (mst_rsp_i.b_valid),
    .in_rdy  (b_in_rdy),
    .in_dat  (mst_rsp_i.b),
    .out_vld (b_out_vld),
    .out_rdy (slv_req_i.b_ready),
    .out_dat (b_out_dat)
  );

  always_comb begin
    mst_req_o         = slv_req_i;
    mst_req_o.r_ready = r_in_rdy;
    mst_req_o.b_ready = b_in_rdy;
  end

  // Copy carries aw/w/ar_ready straight through; R and B come from the buffers.
  always_comb begin
    slv_rsp_o         = mst_rsp_i;
    slv_rsp_o.r       = r_out_dat;
    slv_rsp_o.r_valid = r_out_vld;
    slv_rsp_o.b       = b_out_dat;
    slv_rsp_o.b_valid = b_out_vld;
  end
endmodule
